// File: rtl/step_pulse_gen.sv
// Stepper-motor STEP/DIR pulse generator.
// Converts a requested step period, enable and direction into STEP/DIR pins.
// STEP has a fixed high time and a minimum rising-edge spacing. DIR is held
// stable for a setup time before STEP rises. A signed position count is kept.
// All outputs are registered.
module step_pulse_gen #(
  parameter int WIDTH_WORK = 16,
  parameter int PULSE_W    = 100,
  parameter int DIR_SETUP  = 250,
  parameter int MIN_PERIOD = 200,  // must exceed PULSE_W so LOW is never empty
  parameter int POS_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    dir_in,
  input  logic [WIDTH_WORK-1:0]   period,
  output logic                    drv_step,
  output logic                    drv_dir,
  output logic                    busy,
  output logic                    step_done,
  output logic signed [POS_W-1:0] position
);

  // The shared phase counter must hold the largest of the period word,
  // the setup time, the pulse width and the clamped minimum period.
  localparam int SETUP_BITS = $clog2(DIR_SETUP + 1);
  localparam int PULSE_BITS = $clog2(PULSE_W + 1);
  localparam int MINP_BITS  = $clog2(MIN_PERIOD + 1);
  localparam int MAX_A      = (SETUP_BITS > PULSE_BITS) ? SETUP_BITS : PULSE_BITS;
  localparam int MAX_B      = (MAX_A > MINP_BITS) ? MAX_A : MINP_BITS;
  localparam int CNT_W      = (WIDTH_WORK > MAX_B) ? WIDTH_WORK : MAX_B;

  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] LOW_TRIM   = CNT_W'(PULSE_W + 1);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [CNT_W-1:0]        cnt_reg;
  logic [CNT_W-1:0]        cnt_next;
  logic [CNT_W-1:0]        eff_reg;
  logic [CNT_W-1:0]        eff_next;
  logic                    drv_step_reg;
  logic                    drv_step_next;
  logic                    drv_dir_reg;
  logic                    drv_dir_next;
  logic                    step_done_reg;
  logic                    step_done_next;
  logic                    busy_reg;
  logic signed [POS_W-1:0] position_reg;
  logic signed [POS_W-1:0] position_next;

  logic             start;
  logic             dir_match;
  logic             cnt_zero;
  logic [CNT_W-1:0] period_ext;
  logic [CNT_W-1:0] eff_req;

  // A zero period means "no motion", so it never starts a step.
  assign start      = enable && (period != '0);
  assign dir_match  = (dir_in == drv_dir_reg);
  assign cnt_zero   = (cnt_reg == '0);
  assign period_ext = CNT_W'(period);
  // Clamp the requested period to the minimum STEP spacing.
  assign eff_req    = (period_ext < MIN_P) ? MIN_P : period_ext;

  // State and datapath registers. The reset is asynchronous, so STEP drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      eff_reg       <= '0;
      drv_step_reg  <= 1'b0;
      drv_dir_reg   <= 1'b0;
      step_done_reg <= 1'b0;
      busy_reg      <= 1'b0;
      position_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      eff_reg       <= eff_next;
      drv_step_reg  <= drv_step_next;
      drv_dir_reg   <= drv_dir_next;
      step_done_reg <= step_done_next;
      busy_reg      <= (state_next != ST_IDLE);
      position_reg  <= position_next;
    end
  end

  // Next-state logic. A direction change always goes through SETUP first.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = dir_match ? ST_HIGH : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (cnt_zero) begin
          state_next = (period != '0) ? ST_HIGH : ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (cnt_zero) begin
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        // LOW always runs to completion, so the minimum spacing is kept.
        if (cnt_zero) begin
          if (start) begin
            state_next = dir_match ? ST_HIGH : ST_SETUP;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output and counter updates, driven by which transition is being taken.
  always_comb begin
    cnt_next       = cnt_reg;
    eff_next       = eff_reg;
    drv_step_next  = drv_step_reg;
    drv_dir_next   = drv_dir_reg;
    step_done_next = 1'b0;
    position_next  = position_reg;
    if (state_next == ST_HIGH && state_reg != ST_HIGH) begin
      // A STEP rises now. Latch the spacing for this step only.
      drv_step_next = 1'b1;
      eff_next      = eff_req;
      cnt_next      = PULSE_LOAD;
    end else if (state_next == ST_SETUP && state_reg != ST_SETUP) begin
      // DIR changes here. STEP must wait DIR_SETUP cycles before it rises.
      drv_dir_next = dir_in;
      cnt_next     = SETUP_LOAD;
    end else if (state_next == ST_LOW && state_reg == ST_HIGH) begin
      // The pulse ends. LOW fills out the rest of the latched period.
      drv_step_next  = 1'b0;
      step_done_next = 1'b1;
      position_next  = drv_dir_reg ? (position_reg + POS_ONE) : (position_reg - POS_ONE);
      cnt_next       = eff_reg - LOW_TRIM;
    end else if (state_next == ST_IDLE) begin
      cnt_next = '0;
    end else if (!cnt_zero) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  assign drv_step  = drv_step_reg;
  assign drv_dir   = drv_dir_reg;
  assign busy      = busy_reg;
  assign step_done = step_done_reg;
  assign position  = position_reg;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen.
// Uses a small timestamp model and directed scenarios with literal expectations.
module tb_step_pulse_gen;
  localparam int WIDTH_WORK = 16;
  localparam int PULSE_W    = 4;
  localparam int DIR_SETUP  = 3;
  localparam int MIN_PERIOD = 10;
  localparam int POS_W      = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    enable = 1'b0;
  logic                    dir_in = 1'b0;
  logic [WIDTH_WORK-1:0]   period = '0;
  logic                    drv_step;
  logic                    drv_dir;
  logic                    busy;
  logic                    step_done;
  logic signed [POS_W-1:0] position;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .WIDTH_WORK(WIDTH_WORK),
    .PULSE_W   (PULSE_W),
    .DIR_SETUP (DIR_SETUP),
    .MIN_PERIOD(MIN_PERIOD),
    .POS_W     (POS_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .dir_in   (dir_in),
    .period   (period),
    .drv_step (drv_step),
    .drv_dir  (drv_dir),
    .busy     (busy),
    .step_done(step_done),
    .position (position)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic int eff_of(input logic [WIDTH_WORK-1:0] p);
    return (int'(p) < MIN_PERIOD) ? MIN_PERIOD : int'(p);
  endfunction

  // Timestamp model: remembers when the last STEP rose, when DIR last changed,
  // and when the current step window closes.
  longint                  n         = 0;
  longint                  m_rise_t  = 0;
  longint                  m_dir_t   = 0;
  longint                  m_win_end = 0;
  logic                    m_step    = 1'b0;
  logic                    m_dir     = 1'b0;
  logic                    m_done    = 1'b0;
  logic                    m_busy    = 1'b0;
  logic                    m_setup   = 1'b0;
  logic signed [POS_W-1:0] m_pos     = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_rise_t = 0; m_dir_t = 0; m_win_end = 0;
      m_step = 1'b0; m_dir = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_setup = 1'b0; m_pos = '0;
    end else begin
      n = n + 1;
      m_done = 1'b0;
      if (m_step && n == m_rise_t + PULSE_W) begin
        m_step = 1'b0;
        m_done = 1'b1;
        m_pos  = m_dir ? m_pos + 8'sd1 : m_pos - 8'sd1;
      end
      if (m_setup) begin
        if (!enable) m_setup = 1'b0;
        else if (n == m_dir_t + DIR_SETUP) begin
          m_setup = 1'b0;
          if (period != 0) begin
            m_step = 1'b1; m_rise_t = n; m_win_end = n + eff_of(period);
          end
        end
      end else if (n >= m_win_end && enable && period != 0) begin
        if (dir_in == m_dir) begin
          m_step = 1'b1; m_rise_t = n; m_win_end = n + eff_of(period);
        end else begin
          m_dir = dir_in; m_dir_t = n; m_setup = 1'b1;
        end
      end
      m_busy = m_setup || (n < m_win_end);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("cmp_step", drv_step, m_step);
    check("cmp_dir", drv_dir, m_dir);
    check("cmp_busy", busy, m_busy);
    check("cmp_done", step_done, m_done);
    check("cmp_pos", int'(position), int'(m_pos));
  end

  // Event monitor: records rise times, pulse widths, done pulses and wraps.
  int                      cyc       = 0;
  int                      high_run  = 0;
  int                      done_cnt  = 0;
  int                      dir_viol  = 0;
  int                      wrap_cnt  = 0;
  int                      rise_q[$];
  int                      high_q[$];
  logic                    prev_step = 1'b0;
  logic                    prev_dir  = 1'b0;
  logic signed [POS_W-1:0] prev_pos  = '0;

  always @(negedge clk) begin
    cyc++;
    if (drv_step && !prev_step) rise_q.push_back(cyc);
    if (drv_step) high_run++;
    else if (prev_step) begin
      high_q.push_back(high_run);
      high_run = 0;
    end
    if (step_done) done_cnt++;
    if ((drv_dir != prev_dir) && (drv_step || prev_step)) dir_viol++;
    if (prev_pos == 8'sh7f && position == 8'sh80) wrap_cnt++;
    prev_step = drv_step;
    prev_dir  = drv_dir;
    prev_pos  = position;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  initial begin
    int base;
    int r0;
    int h0;
    int d0;
    int w0;
    int p0;

    #1 rst = 1'b1;
    ticks(2);
    check("rst_step", drv_step, 0);
    check("rst_dir", drv_dir, 0);
    check("rst_busy", busy, 0);
    check("rst_done", step_done, 0);
    check("rst_pos", int'(position), 0);
    rst = 1'b0;

    // 1: continuous run at period 20, direction 0
    enable = 1'b1; dir_in = 1'b0; period = 16'd20;
    base = cyc; r0 = rise_q.size(); h0 = high_q.size(); d0 = done_cnt;
    ticks(100);
    check("s1_rises", rise_q.size() - r0, 5);
    if (rise_q.size() > r0) check("s1_first_rise", rise_q[r0] - base, 1);
    for (int i = r0 + 1; i < rise_q.size(); i++) check("s1_spacing", rise_q[i] - rise_q[i-1], 20);
    for (int i = h0; i < high_q.size(); i++) check("s1_high", high_q[i], 4);
    check("s1_done", done_cnt - d0, 5);
    check("s1_pos", int'(position), -5);
    enable = 1'b0;
    ticks(3);
    check("s1_idle_busy", busy, 0);
    check("s1_no_more", rise_q.size() - r0, 5);
    $display("scenario 1 continuous: rises=%0d done=%0d position=%0d", rise_q.size() - r0, done_cnt - d0, position);

    // 2: period clamp, then period=0 during LOW
    enable = 1'b1; period = 16'd5;
    base = cyc; r0 = rise_q.size(); h0 = high_q.size(); d0 = done_cnt;
    ticks(35);
    check("s2_rises", rise_q.size() - r0, 4);
    for (int i = r0 + 1; i < rise_q.size(); i++) check("s2_spacing", rise_q[i] - rise_q[i-1], 10);
    for (int i = h0; i < high_q.size(); i++) check("s2_high", high_q[i], 4);
    period = 16'd0;
    ticks(5);
    check("s2_busy_low_end", busy, 1);
    tick();
    check("s2_busy_idle", busy, 0);
    ticks(4);
    check("s2_no_more", rise_q.size() - r0, 4);
    check("s2_done", done_cnt - d0, 4);
    check("s2_step_low", drv_step, 0);
    $display("scenario 2 clamp: rises=%0d done=%0d busy=%0d", rise_q.size() - r0, done_cnt - d0, busy);

    // 3: direction reversal requested during LOW
    enable = 1'b1; dir_in = 1'b0; period = 16'd20;
    base = cyc; r0 = rise_q.size(); p0 = int'(position);
    ticks(10);
    dir_in = 1'b1;
    ticks(10);
    check("s3_dir_before", drv_dir, 0);
    tick();
    check("s3_dir_after", drv_dir, 1);
    check("s3_step_at_dir", drv_step, 0);
    ticks(2);
    check("s3_step_setup", drv_step, 0);
    tick();
    check("s3_step_rise", drv_step, 1);
    ticks(4);
    check("s3_pos_back", int'(position), p0);
    ticks(20);
    check("s3_pos_up", int'(position), p0 + 1);
    enable = 1'b0;
    ticks(20);
    check("s3_rises", rise_q.size() - r0, 3);
    if (rise_q.size() >= r0 + 3) check("s3_spacing", rise_q[r0+2] - rise_q[r0+1], 20);
    check("s3_dir_stable", dir_viol, 0);
    check("s3_idle", busy, 0);
    $display("scenario 3 reversal: rises=%0d position=%0d dir=%0d", rise_q.size() - r0, position, drv_dir);

    // 4: enable drops in the second cycle of HIGH
    enable = 1'b1; dir_in = 1'b1; period = 16'd20;
    base = cyc; r0 = rise_q.size(); p0 = int'(position);
    ticks(2);
    check("s4_high", drv_step, 1);
    enable = 1'b0;
    ticks(18);
    check("s4_busy_20", busy, 1);
    tick();
    check("s4_busy_21", busy, 0);
    check("s4_width", high_q[high_q.size()-1], 4);
    ticks(9);
    check("s4_rises", rise_q.size() - r0, 1);
    check("s4_pos", int'(position), p0 + 1);
    $display("scenario 4 enable drop: rises=%0d busy=%0d", rise_q.size() - r0, busy);

    // 5: position wrap from reset, 130 forward steps
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rst_pos", int'(position), 0);
    enable = 1'b1; dir_in = 1'b1; period = 16'd10;
    base = cyc; r0 = rise_q.size(); w0 = wrap_cnt;
    for (int i = 0; i < 1400 && (rise_q.size() - r0) < 130; i++) tick();
    enable = 1'b0;
    ticks(15);
    check("s5_rises", rise_q.size() - r0, 130);
    if (rise_q.size() > r0) check("s5_first_rise", rise_q[r0] - base, 4);
    check("s5_wraps", wrap_cnt - w0, 1);
    check("s5_pos", int'(position), -126);
    check("s5_idle", busy, 0);
    $display("scenario 5 wrap: rises=%0d wraps=%0d position=%0d", rise_q.size() - r0, wrap_cnt - w0, position);

    // 6: asynchronous reset in mid-HIGH, then restart
    enable = 1'b1; dir_in = 1'b1; period = 16'd12;
    ticks(2);
    check("s6_pre_step", drv_step, 1);
    check("s6_pre_pos", int'(position), -126);
    #2 rst = 1'b1;
    #1;
    check("s6_async_step", drv_step, 0);
    check("s6_async_pos", int'(position), 0);
    check("s6_async_busy", busy, 0);
    check("s6_async_dir", drv_dir, 0);
    dir_in = 1'b0;
    tick();
    rst = 1'b0;
    base = cyc; r0 = rise_q.size();
    ticks(30);
    check("s6_rises", rise_q.size() - r0, 3);
    if (rise_q.size() > r0) check("s6_first_rise", rise_q[r0] - base, 1);
    for (int i = r0 + 1; i < rise_q.size(); i++) check("s6_spacing", rise_q[i] - rise_q[i-1], 12);
    enable = 1'b0;
    ticks(15);
    check("s6_idle", busy, 0);
    $display("scenario 6 async reset: rises=%0d position=%0d", rise_q.size() - r0, position);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
Stepper-motor pulse generator directly downstream of the tracking controller.
- Consumes the controller's step-period word (N), motor enable and direction request.
- Produces the physical STEP/DIR pins with a guaranteed pulse width, a minimum step spacing and a direction setup time.
- Keeps a signed position count of issued steps for monitoring.

Parameters:
WIDTH_WORK, 16, width of period input (clock cycles per step)
PULSE_W, 100, STEP high time in clk cycles (2 us at 50 MHz)
DIR_SETUP, 250, cycles DIR must be stable before a STEP rising edge (5 us)
MIN_PERIOD, 200, minimum STEP edge-to-edge spacing in cycles; must be > PULSE_W
POS_W, 32, width of signed position counter

Ports:
clk  input  1  50 MHz system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  motor run request (controller's drv_enable_SM)
dir_in  input  1  requested direction (controller's drv_dir)
period  input  WIDTH_WORK  requested step period in clk cycles (controller's N)
drv_step  output  1  STEP pin, registered
drv_dir  output  1  DIR pin, registered
busy  output  1  high whenever state != IDLE
step_done  output  1  one-cycle pulse per completed STEP high phase
position  output  POS_W  signed step count: +1 per step with drv_dir=1, -1 with drv_dir=0

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - drv_step=0, drv_dir=0, step_done=0, position=0.
  - state=IDLE, all internal counters cleared, so busy=0.
- States: IDLE, SETUP, HIGH, LOW. All outputs are registered.
- Start condition: enable=1 and period!=0, both sampled on the same clk edge.
- Effective period: eff = max(period, MIN_PERIOD).
  - Latched on each entry to HIGH.
  - Changes to period during HIGH or LOW take effect only at the next step.
- IDLE:
  - If start and dir_in==drv_dir: on the same edge, drv_step<=1, latch eff, go HIGH.
    - STEP rises on the edge that samples the start condition.
  - If start and dir_in!=drv_dir: drv_dir<=dir_in, load setup count, go SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - Lasts exactly DIR_SETUP cycles after drv_dir changes.
  - Then drv_step<=1, latch eff, go HIGH.
  - If enable falls during SETUP: go IDLE. drv_dir keeps its new value and no step is issued.
- HIGH:
  - drv_step=1 for exactly PULSE_W cycles; never truncated by enable or dir_in changes.
  - On the leaving edge: drv_step<=0, step_done<=1 for one cycle, position updated by ±1 per drv_dir.
- LOW:
  - Lasts eff-PULSE_W cycles, so STEP rising edges are exactly eff cycles apart in continuous running.
  - The LOW phase always completes in full, even if enable drops; this preserves minimum spacing.
  - At LOW end, with start and dir_in==drv_dir: drv_step<=1, go HIGH (back-to-back).
  - At LOW end, with start and dir_in!=drv_dir: drv_dir<=dir_in, go SETUP.
  - At LOW end otherwise: go IDLE.
- drv_dir never changes while in HIGH or LOW. dir_in is sampled only in IDLE or at LOW end.
- position wraps modulo 2^POS_W (two's complement), with no saturation.
- period==0 is treated as "no motion": no new step is started, and a step already in progress completes normally.
- Simultaneous enable rise and dir change in IDLE: SETUP takes precedence; STEP never rises in the same cycle as a DIR change.
- Reset mid-operation: drv_step drops immediately, and any runt pulse is accepted as a reset consequence.
- After rst deasserts, the first step requires a fresh start condition. If dir_in=1 at that point, a SETUP phase occurs because drv_dir resets to 0.

Test Plan:
Bench overrides for all scenarios: PULSE_W=4, DIR_SETUP=3, MIN_PERIOD=10, POS_W=8.
1. Continuous run: reset, enable=1, dir_in=0, period=20 for 100 cycles -> STEP high 4 cycles, rising edges exactly 20 cycles apart (first on the first enabled edge); 5 step_done pulses; position=-5.
2. Period clamp: period=5 -> rising-edge spacing 10 cycles, high time 4. Then period=0 mid-LOW -> current step completes, then IDLE, busy=0.
3. Direction reversal: dir_in->1 during a LOW phase -> DIR toggles at LOW end, next STEP rises exactly 3 cycles later, position then increments by +1 per step; DIR never changes while STEP=1.
4. Enable drop: enable falls at cycle 2 of HIGH with period=20 -> STEP stays high 4 cycles total, busy falls 20 cycles after that rising edge, no further steps.
5. Wrap: drive 130 steps with dir=1 from reset (POS_W=8) -> position wraps from 127 to -128 and ends at -126.
6. Async reset: assert rst mid-HIGH between clock edges -> drv_step, position and busy clear immediately. After release with enable=1, dir_in=0, period=12 -> stepping restarts at the first clock edge.
